// File: rtl/seq_ripple_adder_param_if.sv
// Operand/result bundle for the chunk-serial adder: the requester drives operands and
// start/enable, and the adder returns the result and its status flags.
interface seq_ripple_adder_param_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output en, start, sub, cin, a, b,
    input  s, cout, ovf, busy, done
  );

  modport slave (
    input  en, start, sub, cin, a, b,
    output s, cout, ovf, busy, done
  );
endinterface

// File: rtl/seq_ripple_adder_param.sv
// Chunk-serial ripple adder/subtractor: adds CHUNK bits per enabled cycle over WIDTH/CHUNK cycles.
// state | meaning
// IDLE  | waiting for start with en=1
// RUN   | adding one chunk per enabled edge
// DONE  | result valid, done pulse high
module seq_ripple_adder_param #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  seq_ripple_adder_param_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [CHUNK-1:0] sum_chunk;
  logic             c_next;
  logic             c_msb;
  logic [WIDTH-1:0] acc_next;

  // Operands shift right each chunk, so the active chunk is always in the low bits.
  always_comb begin
    logic c;
    c         = carry;
    c_msb     = 1'b0;
    sum_chunk = '0;
    for (int j = 0; j < CHUNK; j++) begin
      sum_chunk[j] = a_q[j] ^ b_q[j] ^ c;
      if (j == CHUNK - 1) c_msb = c;
      c = (a_q[j] & b_q[j]) | (c & (a_q[j] ^ b_q[j]));
    end
    c_next   = c;
    acc_next = (acc >> CHUNK) | (WIDTH'(sum_chunk) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.en) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub ? 1'b1 : bus.cin;
            cnt    <= '0;
            acc    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          acc   <= acc_next;
          carry <= c_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            s_q    <= acc_next;
            cout_q <= c_next;
            ovf_q  <= c_next ^ c_msb;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_seq_ripple_adder_param.sv
// Drives four adders (CHUNK = 1,2,4,8, WIDTH = 8) from shared stimulus; directed checks
// use the CHUNK=2 instance, the random sweep compares all four against an arithmetic model.
module tb_seq_ripple_adder_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic [7:0] s_o [4];
  logic [3:0] cout_o, ovf_o, busy_o, done_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    seq_ripple_adder_param_if #(.WIDTH(8)) bus ();
    assign bus.en    = en;
    assign bus.start = start;
    assign bus.sub   = sub;
    assign bus.cin   = cin;
    assign bus.a     = a;
    assign bus.b     = b;
    seq_ripple_adder_param #(.WIDTH(8), .CHUNK(1 << g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign s_o[g]    = bus.s;
    assign cout_o[g] = bus.cout;
    assign ovf_o[g]  = bus.ovf;
    assign busy_o[g] = bus.busy;
    assign done_o[g] = bus.done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns {cout, ovf, s} from integer arithmetic on the operand values.
  function automatic logic [9:0] ref_model(input logic [7:0] x, y, input logic m, ci);
    int ux, uy, sx, sy, us, ss;
    logic co;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (m) begin
      us = ux - uy;
      ss = sx - sy;
      co = (ux >= uy);
    end else begin
      us = ux + uy + int'(ci);
      ss = sx + sy + int'(ci);
      co = (us > 255);
    end
    return {co, (ss > 127 || ss < -128), us[7:0]};
  endfunction

  // Launches one op on the CHUNK=2 instance; optional 3-cycle stall and a start pulse while busy.
  task automatic run_op(input string tag, input logic [7:0] ta, tb_, input logic tsub, tcin,
                        input logic [7:0] es, input logic ec, eo, input int elat,
                        input int stall_at, input int pulse_at);
    int lat;
    a = ta; b = tb_; sub = tsub; cin = tcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      if (i == stall_at) en = 1'b0;
      if (i == stall_at + 3) en = 1'b1;
      if (i == pulse_at) start = 1'b1;
      if (i == pulse_at + 1) start = 1'b0;
      @(negedge clk);
      if (done_o[1]) begin
        lat = i;
        break;
      end
      if (busy_o[1] !== 1'b1) chk({tag, "_busy"}, busy_o[1], 1);
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_s"}, s_o[1], es);
    chk({tag, "_cout"}, cout_o[1], ec);
    chk({tag, "_ovf"}, ovf_o[1], eo);
  endtask

  logic [9:0] r;
  logic [7:0] held;
  int lat_g [4];
  bit seen [4];
  int waits;
  logic [7:0] ra, rb;
  logic rs, rc;

  initial begin
    #12;
    @(negedge clk);
    chk("rst_s", s_o[1], 0);
    chk("rst_flags", {cout_o[1], ovf_o[1], busy_o[1], done_o[1]}, 0);

    rst_n = 1'b1;
    en    = 1'b1;
    run_op("add_3_5", 8'd3, 8'd5, 1'b0, 1'b0, 8'd8, 1'b0, 1'b0, 4, -1, -1);
    @(negedge clk);
    chk("done_pulse_width", done_o[1], 0);
    run_op("add_200_100_c", 8'd200, 8'd100, 1'b0, 1'b1, 8'd45, 1'b1, 1'b0, 4, -1, -1);
    @(negedge clk);
    run_op("add_127_1", 8'd127, 8'd1, 1'b0, 1'b0, 8'd128, 1'b0, 1'b1, 4, -1, -1);
    @(negedge clk);
    run_op("sub_5_6", 8'd5, 8'd6, 1'b1, 1'b1, 8'd255, 1'b0, 1'b0, 4, -1, -1);
    @(negedge clk);
    run_op("sub_128_1", 8'd128, 8'd1, 1'b1, 1'b0, 8'd127, 1'b1, 1'b1, 4, -1, -1);
    @(negedge clk);

    run_op("stall", 8'd77, 8'd99, 1'b0, 1'b0, 8'd176, 1'b0, 1'b1, 7, 2, -1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_done_held", done_o[1], 1);
    chk("stall_s_held", s_o[1], 176);
    en = 1'b1;
    @(negedge clk);
    chk("stall_done_clear", {done_o[1], busy_o[1]}, 0);

    run_op("busy_start", 8'd10, 8'd20, 1'b0, 1'b0, 8'd30, 1'b0, 1'b0, 4, -1, 2);
    waits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_o[1]) waits++;
    end
    chk("busy_start_no_second_done", waits, 0);

    a = 8'd1; b = 8'd2; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_s", s_o[1], 0);
    chk("async_rst_flags", {cout_o[1], ovf_o[1], busy_o[1], done_o[1]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    waits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_o[1]) waits++;
    end
    chk("rst_abort_no_done", waits, 0);
    run_op("after_rst", 8'd250, 8'd10, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 4, -1, -1);
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      waits = 0;
      while (busy_o != 4'b0 && waits < 20) begin
        @(negedge clk);
        waits++;
      end
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      if (t == 0) begin ra = 8'hff; rb = 8'h01; rs = 1'b0; rc = 1'b1; end
      if (t == 1) begin ra = 8'h00; rb = 8'h00; rs = 1'b1; rc = 1'b0; end
      r = ref_model(ra, rb, rs, rc);
      a = ra; b = rb; sub = rs; cin = rc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom);
      for (int g = 0; g < 4; g++) begin seen[g] = 1'b0; lat_g[g] = -1; end
      for (int i = 1; i <= 12; i++) begin
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
          if (done_o[g] && !seen[g]) begin
            seen[g]  = 1'b1;
            lat_g[g] = i;
            chk($sformatf("sweep_c%0d_s", 1 << g), s_o[g], r[7:0]);
            chk($sformatf("sweep_c%0d_cout", 1 << g), cout_o[g], r[9]);
            chk($sformatf("sweep_c%0d_ovf", 1 << g), ovf_o[g], r[8]);
          end
        end
      end
      for (int g = 0; g < 4; g++)
        chk($sformatf("sweep_c%0d_lat", 1 << g), lat_g[g], 8 >> g);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
